// File: rtl/shot_scheduler_if.sv
// Request/kill/scan bundle for shot_scheduler; the scheduler is the slave.
// All outputs are registered with one-cycle latency; there is no backpressure because requests are single-cycle pulses.
interface shot_scheduler_if;
   logic       fire_p;
   logic [8:0] p_x;
   logic [8:0] p_y;
   logic       fire_e;
   logic [8:0] e_x;
   logic [8:0] e_y;
   logic       kill_valid;
   logic [2:0] kill_idx;
   logic [8:0] scan_x;
   logic [8:0] scan_y;
   logic       shot_pix;
   logic       shot_owner;
   logic       grant_p;
   logic       grant_e;
   logic       deny;
   logic [3:0] active_cnt;

   modport master (
      output fire_p, p_x, p_y, fire_e, e_x, e_y, kill_valid, kill_idx, scan_x, scan_y,
      input  shot_pix, shot_owner, grant_p, grant_e, deny, active_cnt
   );
   modport slave (
      input  fire_p, p_x, p_y, fire_e, e_x, e_y, kill_valid, kill_idx, scan_x, scan_y,
      output shot_pix, shot_owner, grant_p, grant_e, deny, active_cnt
   );
endinterface

// File: rtl/shot_scheduler.sv
// Shared projectile pool: arbitrates player/enemy fire, steps shots on a divided tick, registered 1-cycle grant/deny/pixel outputs.
// No backpressure: a request that cannot be served is dropped with deny. SHOT_COOLDOWN_EN adds per-requester cooldown.
module shot_scheduler #(
   parameter int SLOTS    = 4,
   parameter int TICK_DIV = 20000,
   parameter int Y_TOP    = 0,
   parameter int Y_BOTTOM = 237,
   parameter int X_OFFSET = 3,
   parameter int COOLDOWN = 8
) (
   input logic              clk,
   input logic              rst_n,
   shot_scheduler_if.slave  bus
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0]    tcnt_q, tcnt_d;
   logic             tick;
   logic [SLOTS-1:0] act_q, act_d, own_q, own_d;
   logic [8:0]       x_q [SLOTS];
   logic [8:0]       x_d [SLOTS];
   logic [8:0]       y_q [SLOTS];
   logic [8:0]       y_d [SLOTS];
   logic             ptr_q, ptr_d;
   logic [2:0]       f0, f1, se;
   logic [3:0]       nfree, cnt_d;
   logic             blk_p, blk_e, req_p, req_e, gnt_p, gnt_e, dny, hit, hown;
   logic             pix_q, pown_q, gp_q, ge_q, dn_q;
   logic [3:0]       cnt_q;

   assign tick   = (tcnt_q == CW'(TICK_DIV - 1));
   assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

   function automatic logic covers(input logic [8:0] sx, input logic [8:0] sy,
                                   input logic [8:0] ox, input logic [8:0] oy);
      logic [8:0] dx, dy;
      dx = sx - ox;
      dy = sy - oy;
      return (dx <= 9'd1) && (dy <= 9'd1);
   endfunction

   // Lowest and second-lowest free slot, from registered state only.
   always_comb begin
      f0    = '0;
      f1    = '0;
      nfree = '0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!act_q[i]) begin
            if (nfree == 4'd0)      f0 = 3'(i);
            else if (nfree == 4'd1) f1 = 3'(i);
            nfree = nfree + 4'd1;
         end
      end
   end

`ifdef SHOT_COOLDOWN_EN
   localparam int DW = $clog2(COOLDOWN + 1) + 1;
   logic [DW-1:0] cdp_q, cde_q;

   assign blk_p = (cdp_q != '0);
   assign blk_e = (cde_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdp_q <= '0;
         cde_q <= '0;
      end else begin
         if (gnt_p)              cdp_q <= DW'(COOLDOWN);
         else if (tick && blk_p) cdp_q <= cdp_q - 1'b1;
         if (gnt_e)              cde_q <= DW'(COOLDOWN);
         else if (tick && blk_e) cde_q <= cde_q - 1'b1;
      end
   end
`else
   assign blk_p = 1'b0;
   assign blk_e = 1'b0;
`endif

   always_comb begin
      req_p = bus.fire_p & ~blk_p;
      req_e = bus.fire_e & ~blk_e;
      gnt_p = 1'b0;
      gnt_e = 1'b0;
      dny   = (bus.fire_p & blk_p) | (bus.fire_e & blk_e);
      ptr_d = ptr_q;
      if (req_p && req_e) begin
         if (nfree >= 4'd2) begin
            gnt_p = 1'b1;
            gnt_e = 1'b1;
         end else if (nfree == 4'd1) begin
            // Single slot contested: pointer owner wins, pointer moves to the loser.
            gnt_p = ~ptr_q;
            gnt_e = ptr_q;
            dny   = 1'b1;
            ptr_d = ~ptr_q;
         end else begin
            dny = 1'b1;
         end
      end else if (req_p || req_e) begin
         if (nfree != 4'd0) begin
            gnt_p = req_p;
            gnt_e = req_e;
         end else begin
            dny = 1'b1;
         end
      end
      se = gnt_p ? f1 : f0;
   end

   always_comb begin
      act_d = act_q;
      own_d = own_q;
      x_d   = x_q;
      y_d   = y_q;
      for (int i = 0; i < SLOTS; i++) begin
         if (act_q[i] && tick) begin
            if (!own_q[i]) begin
               if (y_q[i] == 9'(Y_TOP)) act_d[i] = 1'b0;
               else                     y_d[i]   = y_q[i] - 9'd1;
            end else begin
               if (y_q[i] == 9'(Y_BOTTOM)) act_d[i] = 1'b0;
               else                        y_d[i]   = y_q[i] + 9'd1;
            end
         end
         // Kill overrides the step; indices beyond the pool never match.
         if (bus.kill_valid && bus.kill_idx == 3'(i) && act_q[i]) begin
            act_d[i] = 1'b0;
            y_d[i]   = y_q[i];
         end
         if (gnt_p && f0 == 3'(i)) begin
            act_d[i] = 1'b1;
            own_d[i] = 1'b0;
            x_d[i]   = bus.p_x + 9'(X_OFFSET);
            y_d[i]   = bus.p_y;
         end
         if (gnt_e && se == 3'(i)) begin
            act_d[i] = 1'b1;
            own_d[i] = 1'b1;
            x_d[i]   = bus.e_x + 9'(X_OFFSET);
            y_d[i]   = bus.e_y;
         end
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < SLOTS; i++) cnt_d = cnt_d + {3'd0, act_d[i]};
   end

   // Scan from the top index down so the lowest index sets the owner.
   always_comb begin
      hit  = 1'b0;
      hown = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (act_q[i] && covers(bus.scan_x, bus.scan_y, x_q[i], y_q[i])) begin
            hit  = 1'b1;
            hown = own_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q <= '0;
         act_q  <= '0;
         own_q  <= '0;
         ptr_q  <= 1'b0;
         for (int i = 0; i < SLOTS; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
         pix_q  <= 1'b0;
         pown_q <= 1'b0;
         gp_q   <= 1'b0;
         ge_q   <= 1'b0;
         dn_q   <= 1'b0;
         cnt_q  <= '0;
      end else begin
         tcnt_q <= tcnt_d;
         act_q  <= act_d;
         own_q  <= own_d;
         ptr_q  <= ptr_d;
         x_q    <= x_d;
         y_q    <= y_d;
         pix_q  <= hit;
         pown_q <= hown;
         gp_q   <= gnt_p;
         ge_q   <= gnt_e;
         dn_q   <= dny;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.shot_pix   = pix_q;
   assign bus.shot_owner = pown_q;
   assign bus.grant_p    = gp_q;
   assign bus.grant_e    = ge_q;
   assign bus.deny       = dn_q;
   assign bus.active_cnt = cnt_q;
endmodule

// File: tb/tb_shot_scheduler.sv
// Bench for shot_scheduler: directed scenarios plus randomized traffic against a slot-pool model.
module tb_shot_scheduler;
   localparam int SLOTS = 4;
   localparam int TD    = 4;
   localparam int YT    = 0;
   localparam int YB    = 237;
   localparam int XO    = 3;
   localparam int CD    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shot_scheduler_if bus ();

   shot_scheduler #(
      .SLOTS(SLOTS), .TICK_DIV(TD), .Y_TOP(YT), .Y_BOTTOM(YB), .X_OFFSET(XO), .COOLDOWN(CD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   int m_act [SLOTS];
   int m_own [SLOTS];
   int m_x   [SLOTS];
   int m_y   [SLOTS];
   int m_ptr, m_tc, m_ticks, m_cdp, m_cde;
   logic       e_pix, e_own, e_gp, e_ge, e_dn;
   logic [3:0] e_cnt;

   task automatic model_reset();
      for (int i = 0; i < SLOTS; i++) begin
         m_act[i] = 0; m_own[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_ptr = 0; m_tc = 0; m_ticks = 0; m_cdp = 0; m_cde = 0;
   endtask

   // Predicts the outputs visible after the next rising edge from the current inputs.
   task automatic model_step();
      int fq[$];
      bit tk, rp, re, gp, ge, dn;
      int n_act [SLOTS];
      int n_own [SLOTS];
      int n_x   [SLOTS];
      int n_y   [SLOTS];
      int s, k, cnt;
      tk = (m_tc % TD) == TD - 1;
      e_pix = 1'b0;
      e_own = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--)
         if (m_act[i] != 0 && ((int'(bus.scan_x) - m_x[i]) & 511) <= 1 &&
             ((int'(bus.scan_y) - m_y[i]) & 511) <= 1) begin
            e_pix = 1'b1;
            e_own = (m_own[i] != 0);
         end
      for (int i = 0; i < SLOTS; i++) if (m_act[i] == 0) fq.push_back(i);
      rp = bus.fire_p; re = bus.fire_e; gp = 0; ge = 0; dn = 0;
`ifdef SHOT_COOLDOWN_EN
      if (rp && m_cdp > 0) begin rp = 0; dn = 1; end
      if (re && m_cde > 0) begin re = 0; dn = 1; end
`endif
      if (rp && re) begin
         if (fq.size() >= 2) begin gp = 1; ge = 1; end
         else if (fq.size() == 1) begin
            dn = 1;
            if (m_ptr == 0) gp = 1; else ge = 1;
            m_ptr = 1 - m_ptr;
         end else dn = 1;
      end else if (rp || re) begin
         if (fq.size() > 0) begin gp = rp; ge = re; end
         else dn = 1;
      end
      n_act = m_act; n_own = m_own; n_x = m_x; n_y = m_y;
      if (tk)
         for (int i = 0; i < SLOTS; i++)
            if (m_act[i] != 0) begin
               if (m_own[i] == 0) begin
                  if (m_y[i] == YT) n_act[i] = 0; else n_y[i] = m_y[i] - 1;
               end else begin
                  if (m_y[i] == YB) n_act[i] = 0; else n_y[i] = (m_y[i] + 1) & 511;
               end
            end
      k = int'(bus.kill_idx);
      if (bus.kill_valid && k < SLOTS && m_act[k] != 0) begin
         n_act[k] = 0;
         n_y[k]   = m_y[k];
      end
      if (gp) begin
         s = fq.pop_front();
         n_act[s] = 1; n_own[s] = 0; n_x[s] = (int'(bus.p_x) + XO) & 511; n_y[s] = int'(bus.p_y);
      end
      if (ge) begin
         s = fq.pop_front();
         n_act[s] = 1; n_own[s] = 1; n_x[s] = (int'(bus.e_x) + XO) & 511; n_y[s] = int'(bus.e_y);
      end
      if (gp) m_cdp = CD; else if (tk && m_cdp > 0) m_cdp--;
      if (ge) m_cde = CD; else if (tk && m_cde > 0) m_cde--;
      m_act = n_act; m_own = n_own; m_x = n_x; m_y = n_y;
      m_tc++;
      if (tk) m_ticks++;
      cnt = 0;
      for (int i = 0; i < SLOTS; i++) cnt += m_act[i];
      e_gp = gp; e_ge = ge; e_dn = dn; e_cnt = 4'(cnt);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      bus.fire_p = 1'b0;
      bus.fire_e = 1'b0;
      bus.kill_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.fire_p = 1'b0; bus.fire_e = 1'b0; bus.kill_valid = 1'b0; bus.kill_idx = '0;
      bus.p_x = '0; bus.p_y = '0; bus.e_x = '0; bus.e_y = '0;
      bus.scan_x = 9'd511; bus.scan_y = 9'd511;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({bus.shot_pix, bus.shot_owner, bus.grant_p, bus.grant_e, bus.deny, bus.active_cnt} !== 9'd0) begin
         errors++;
         $display("FAIL reset_outputs got pix=%b own=%b gp=%b ge=%b dn=%b cnt=%0d want all 0",
                  bus.shot_pix, bus.shot_owner, bus.grant_p, bus.grant_e, bus.deny, bus.active_cnt);
      end
   endtask

   task automatic test_single_launch();
      do_reset();
      bus.p_x = 9'd150; bus.p_y = 9'd200; bus.fire_p = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b1 || bus.active_cnt !== 4'd1 || bus.deny !== 1'b0) begin
         errors++;
         $display("FAIL single_grant got gp=%b cnt=%0d dn=%b want gp=1 cnt=1 dn=0", bus.grant_p, bus.active_cnt, bus.deny);
      end
      step();
      checks++;
      if (bus.grant_p !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse got gp=%b want 0", bus.grant_p);
      end
      while (m_ticks < 3) step();
      bus.scan_x = 9'd154; bus.scan_y = 9'd198;
      step();
      checks++;
      if (bus.shot_pix !== 1'b1 || bus.shot_owner !== 1'b0) begin
         errors++;
         $display("FAIL single_pix_hit got pix=%b own=%b want pix=1 own=0", bus.shot_pix, bus.shot_owner);
      end
      bus.scan_x = 9'd153; bus.scan_y = 9'd196;
      step();
      checks++;
      if (bus.shot_pix !== 1'b0) begin
         errors++;
         $display("FAIL single_pix_miss got pix=%b want 0", bus.shot_pix);
      end
   endtask

   task automatic test_dual_grant();
      do_reset();
      bus.p_x = 9'd10;  bus.p_y = 9'd50; bus.fire_p = 1'b1;
      bus.e_x = 9'd100; bus.e_y = 9'd20; bus.fire_e = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b1 || bus.grant_e !== 1'b1 || bus.deny !== 1'b0 || bus.active_cnt !== 4'd2) begin
         errors++;
         $display("FAIL dual_grant got gp=%b ge=%b dn=%b cnt=%0d want 1 1 0 2",
                  bus.grant_p, bus.grant_e, bus.deny, bus.active_cnt);
      end
      bus.kill_valid = 1'b1; bus.kill_idx = 3'd0;
      step();
      checks++;
      if (bus.active_cnt !== 4'd1) begin
         errors++;
         $display("FAIL dual_kill0_cnt got %0d want 1", bus.active_cnt);
      end
      bus.scan_x = 9'd13; bus.scan_y = 9'd50;
      step();
      checks++;
      if (bus.shot_pix !== 1'b0) begin
         errors++;
         $display("FAIL dual_player_slot0 got pix=%b want 0", bus.shot_pix);
      end
      bus.scan_x = 9'd104; bus.scan_y = 9'd21;
      step();
      checks++;
      if (bus.shot_pix !== 1'b1 || bus.shot_owner !== 1'b1) begin
         errors++;
         $display("FAIL dual_enemy_pix got pix=%b own=%b want pix=1 own=1", bus.shot_pix, bus.shot_owner);
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.p_x = 9'(20 + 20 * i); bus.p_y = 9'd100; bus.fire_p = 1'b1;
         step();
      end
      checks++;
      if (bus.active_cnt !== 4'd3) begin
         errors++;
         $display("FAIL contend_fill got cnt=%0d want 3", bus.active_cnt);
      end
      bus.p_x = 9'd80; bus.p_y = 9'd100; bus.fire_p = 1'b1;
      bus.e_x = 9'd80; bus.e_y = 9'd10;  bus.fire_e = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b1 || bus.grant_e !== 1'b0 || bus.deny !== 1'b1 || bus.active_cnt !== 4'd4) begin
         errors++;
         $display("FAIL contend_player_wins got gp=%b ge=%b dn=%b cnt=%0d want 1 0 1 4",
                  bus.grant_p, bus.grant_e, bus.deny, bus.active_cnt);
      end
      bus.fire_p = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b0 || bus.deny !== 1'b1) begin
         errors++;
         $display("FAIL contend_full_deny got gp=%b dn=%b want gp=0 dn=1", bus.grant_p, bus.deny);
      end
      bus.kill_valid = 1'b1; bus.kill_idx = 3'd3;
      step();
      bus.fire_p = 1'b1; bus.fire_e = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b0 || bus.grant_e !== 1'b1 || bus.deny !== 1'b1 || bus.active_cnt !== 4'd4) begin
         errors++;
         $display("FAIL contend_enemy_wins got gp=%b ge=%b dn=%b cnt=%0d want 0 1 1 4",
                  bus.grant_p, bus.grant_e, bus.deny, bus.active_cnt);
      end
   endtask

   task automatic test_retire();
      do_reset();
      bus.e_x = 9'd30; bus.e_y = 9'd235; bus.fire_e = 1'b1;
      step();
      repeat (9) step();
      bus.scan_x = 9'd33; bus.scan_y = 9'd238;
      step();
      checks++;
      if (bus.shot_pix !== 1'b1 || bus.active_cnt !== 4'd1) begin
         errors++;
         $display("FAIL retire_at_bottom got pix=%b cnt=%0d want pix=1 cnt=1", bus.shot_pix, bus.active_cnt);
      end
      step();
      checks++;
      if (bus.active_cnt !== 4'd0) begin
         errors++;
         $display("FAIL retire_cnt got %0d want 0", bus.active_cnt);
      end
   endtask

   task automatic test_kill_tick();
      do_reset();
      bus.p_x = 9'd50; bus.p_y = 9'd100; bus.fire_p = 1'b1;
      bus.e_x = 9'd70; bus.e_y = 9'd50;  bus.fire_e = 1'b1;
      step();
      step();
      step();
      bus.kill_valid = 1'b1; bus.kill_idx = 3'd1;
      step();
      checks++;
      if (bus.active_cnt !== 4'd1) begin
         errors++;
         $display("FAIL kill_on_tick got cnt=%0d want 1", bus.active_cnt);
      end
      bus.kill_valid = 1'b1; bus.kill_idx = 3'd7;
      bus.scan_x = 9'd53; bus.scan_y = 9'd99;
      step();
      checks++;
      if (bus.active_cnt !== 4'd1 || bus.shot_pix !== 1'b1) begin
         errors++;
         $display("FAIL kill_out_of_range got cnt=%0d pix=%b want cnt=1 pix=1", bus.active_cnt, bus.shot_pix);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      bus.p_x = 9'd200; bus.p_y = 9'd100; bus.fire_p = 1'b1;
      step();
      bus.fire_p = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.active_cnt !== 4'd0 || bus.grant_p !== 1'b0) begin
         errors++;
         $display("FAIL midflight_reset got cnt=%0d gp=%b want 0 0", bus.active_cnt, bus.grant_p);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.grant_p !== 1'b0 || bus.active_cnt !== 4'd0) begin
         errors++;
         $display("FAIL midflight_no_grant got gp=%b cnt=%0d want 0 0", bus.grant_p, bus.active_cnt);
      end
      bus.fire_p = 1'b0;
      model_reset();
      rst_n = 1'b1;
   endtask

`ifdef SHOT_COOLDOWN_EN
   task automatic test_cooldown();
      do_reset();
      bus.p_x = 9'd10; bus.p_y = 9'd100; bus.fire_p = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b1) begin
         errors++;
         $display("FAIL cooldown_first got gp=%b want 1", bus.grant_p);
      end
      repeat (3) step();
      bus.fire_p = 1'b1;
      step();
      checks++;
      if (bus.deny !== 1'b1 || bus.grant_p !== 1'b0) begin
         errors++;
         $display("FAIL cooldown_block got dn=%b gp=%b want dn=1 gp=0", bus.deny, bus.grant_p);
      end
      repeat (3) step();
      bus.fire_p = 1'b1;
      step();
      checks++;
      if (bus.grant_p !== 1'b1 || bus.deny !== 1'b0) begin
         errors++;
         $display("FAIL cooldown_release got gp=%b dn=%b want gp=1 dn=0", bus.grant_p, bus.deny);
      end
   endtask
`endif

   task automatic test_random();
      int j;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         bus.fire_p = ($urandom_range(0, 3) == 0);
         bus.fire_e = ($urandom_range(0, 3) == 0);
         bus.p_x = 9'($urandom_range(0, 511));
         bus.e_x = 9'($urandom_range(0, 511));
         bus.p_y = $urandom_range(0, 1) ? 9'($urandom_range(0, 12)) : 9'($urandom_range(0, 239));
         bus.e_y = $urandom_range(0, 1) ? 9'($urandom_range(225, 237)) : 9'($urandom_range(0, 237));
         bus.kill_valid = ($urandom_range(0, 7) == 0);
         bus.kill_idx = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            j = $urandom_range(0, SLOTS - 1);
            bus.scan_x = 9'((m_x[j] + $urandom_range(0, 3) + 511) & 511);
            bus.scan_y = 9'((m_y[j] + $urandom_range(0, 3) + 511) & 511);
         end else begin
            bus.scan_x = 9'($urandom_range(0, 511));
            bus.scan_y = 9'($urandom_range(0, 511));
         end
         step();
         checks++;
         if (bus.shot_pix !== e_pix) begin
            errors++;
            $display("FAIL rand_pix cycle %0d got %b want %b", c, bus.shot_pix, e_pix);
         end
         checks++;
         if (bus.shot_pix === 1'b1 && bus.shot_owner !== e_own) begin
            errors++;
            $display("FAIL rand_owner cycle %0d got %b want %b", c, bus.shot_owner, e_own);
         end
         checks++;
         if (bus.grant_p !== e_gp || bus.grant_e !== e_ge) begin
            errors++;
            $display("FAIL rand_grant cycle %0d got p=%b e=%b want p=%b e=%b", c, bus.grant_p, bus.grant_e, e_gp, e_ge);
         end
         checks++;
         if (bus.deny !== e_dn) begin
            errors++;
            $display("FAIL rand_deny cycle %0d got %b want %b", c, bus.deny, e_dn);
         end
         checks++;
         if (bus.active_cnt !== e_cnt) begin
            errors++;
            $display("FAIL rand_cnt cycle %0d got %0d want %0d", c, bus.active_cnt, e_cnt);
         end
      end
   endtask

   initial begin
      bus.fire_p = 1'b0; bus.fire_e = 1'b0; bus.kill_valid = 1'b0; bus.kill_idx = '0;
      bus.p_x = '0; bus.p_y = '0; bus.e_x = '0; bus.e_y = '0;
      bus.scan_x = '0; bus.scan_y = '0;
      model_reset();
      test_reset();
      test_single_launch();
      test_dual_grant();
      test_contention();
      test_retire();
      test_kill_tick();
      test_reset_midflight();
`ifdef SHOT_COOLDOWN_EN
      test_cooldown();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/shot_scheduler.md
Name: shot_scheduler

Overview:
- Owns a shared pool of projectile slots for the shooter game.
- Two requesters compete for the pool: the player (shots travel up) and the enemy (shots travel down).
- Arbitrates fire requests, allocates free slots, and steps all live shots on a divided tick.
- Frees slots at the screen edge or on a kill command, and produces a registered per-pixel "shot present" signal for the VGA colour mux.

Parameters:
- SLOTS, 4, number of projectile slots (2..8).
- TICK_DIV, 20000, clk cycles per movement step (one step every TICK_DIV cycles).
- Y_TOP, 0, row at which a player shot is retired.
- Y_BOTTOM, 237, row at which an enemy shot is retired.
- X_OFFSET, 3, column offset added to requester X at launch (sprite centre).
- COOLDOWN, 8, movement ticks a requester is blocked after a grant (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fire_p  in  1  player fire request, single-cycle pulse (edge-detected upstream).
- p_x  in  9  player sprite X.
- p_y  in  9  player sprite Y.
- fire_e  in  1  enemy fire request, single-cycle pulse.
- e_x  in  9  enemy sprite X.
- e_y  in  9  enemy sprite Y.
- kill_valid  in  1  retire the slot given by kill_idx.
- kill_idx  in  3  slot index to retire.
- scan_x  in  9  current pixel column (H_pos).
- scan_y  in  9  current pixel row (V_pos).
- shot_pix  out  1  registered: the pixel lies on any live shot.
- shot_owner  out  1  registered: owner of the hit shot (0 = player, 1 = enemy); lowest index wins on overlap.
- grant_p  out  1  pulse: player shot launched.
- grant_e  out  1  pulse: enemy shot launched.
- deny  out  1  pulse: a request was dropped (no slot available or lost arbitration).
- active_cnt  out  4  number of live slots.

Behaviour:
- Reset (asynchronous, rst_n low): all slots inactive with x/y = 0; tick counter = 0; round-robin pointer set to player; cooldowns cleared. All outputs are 0.
- Tick: the counter counts 0..TICK_DIV-1, and tick is high for one cycle when the counter wraps.
- Per-slot state: active, owner, x[8:0], y[8:0].
- Free-slot search uses registered state only. The lowest-index inactive slot is chosen; with two grants in one cycle, the second grant takes the next free slot.
- Arbitration:
  - Single request with a free slot: grant.
  - Both requests with at least 2 free slots: grant both; pointer unchanged.
  - Both requests with exactly 1 free slot: the pointer's owner wins, the loser gets deny, and the pointer flips to the loser.
  - No free slot: each request gets deny.
- Launch: the slot loads x = req_x + X_OFFSET (9-bit, wraps mod 512), y = req_y, and the owner.
  - The grant pulse and active flag take effect on the cycle after the request.
  - The launched slot does not move on the launch cycle, even if tick is high.
- Movement on tick, per active slot:
  - Player shot: if y == Y_TOP, retire; else y decrements by 1.
  - Enemy shot: if y == Y_BOTTOM, retire; else y increments by 1.
  - The retire check uses the pre-step value.
- Kill: when kill_valid is high, slot kill_idx becomes inactive next cycle.
  - Kill has priority over movement in the same cycle.
  - kill_idx >= SLOTS or an already-inactive slot: no effect.
  - A slot freed by kill is not reusable until the following cycle.
- Pixel hit: a shot covers the 2x2 box scan_x in {x, x+1} and scan_y in {y, y+1}, using 9-bit compare with wrap. shot_pix and shot_owner are registered (1-cycle latency).
- active_cnt equals the popcount of active flags and updates one cycle after any change.
- Reset mid-flight clears all slots immediately; no grant is issued for a request pulse coincident with reset.

Optional Feature:
- Macro: SHOT_COOLDOWN_EN.
- Defined: each requester has a cooldown counter loaded with COOLDOWN on its grant and decremented on each tick.
  - A request while that counter is non-zero produces deny and consumes no slot.
  - A requester blocked by cooldown does not contend in arbitration, so the other requester wins uncontested.
- Undefined: no cooldown logic; requests are limited only by slot availability.

Test Plan:
- Reset, then fire_p with p_x=150, p_y=200 → next cycle grant_p=1, slot 0 active at x=153, y=200, active_cnt=1. After 3 ticks y=197. shot_pix=1 one cycle after scan=(154,198).
- fire_p and fire_e in the same cycle with 4 free slots → grant_p=1 and grant_e=1; player in slot 0, enemy in slot 1; active_cnt=2; deny=0.
- Fill 3 of 4 slots, then fire_p and fire_e together → player granted, deny=1, pointer flips. Kill the new shot, then repeat the simultaneous request → enemy granted.
- Enemy shot launched at e_y=235 with Y_BOTTOM=237, TICK_DIV=4 → y reaches 237 after 2 ticks and retires on the 3rd tick; active_cnt returns to 0.
- kill_valid with kill_idx=1 on the same cycle as a tick → slot 1 inactive with no step applied. kill_idx=7 with SLOTS=4 → no change.
- SHOT_COOLDOWN_EN defined, COOLDOWN=2: fire_p granted, fire_p again 1 tick later → deny=1; fire_p after 2 ticks → grant_p=1.
